// File: rtl/midi_pkg.sv
// Shared MIDI parser types and byte constants.
package midi_pkg;

    typedef enum logic [2:0] {
        NOTE_OFF = 3'd0,
        NOTE_ON  = 3'd1,
        POLY_AT  = 3'd2,
        CTRL     = 3'd3,
        PROG     = 3'd4,
        CHAN_AT  = 3'd5,
        PITCH    = 3'd6
    } msg_type_t;

    typedef enum logic [1:0] {
        NO_STATUS = 2'd0,
        WAIT_D1   = 2'd1,
        WAIT_D2   = 2'd2,
        SYSEX     = 2'd3
    } parse_state_t;

    localparam logic [7:0] ST_NOTE_OFF = 8'h80;
    localparam logic [7:0] ST_NOTE_ON  = 8'h90;
    localparam logic [7:0] ST_POLY_AT  = 8'hA0;
    localparam logic [7:0] ST_CTRL     = 8'hB0;
    localparam logic [7:0] ST_PROG     = 8'hC0;
    localparam logic [7:0] ST_CHAN_AT  = 8'hD0;
    localparam logic [7:0] ST_PITCH    = 8'hE0;

    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_MIN      = 8'hF8;

endpackage

// File: rtl/midi_status_decode.sv
// Combinational classification of a MIDI status byte.
module midi_status_decode
    import midi_pkg::*;
(
    input  logic [7:0] status_byte,
    output msg_type_t  msg_type,
    output logic       two_data,
    output logic       is_realtime,
    output logic       is_sysex_start,
    output logic       is_syscommon
);

    always_comb begin
        msg_type = NOTE_OFF;
        two_data = 1'b1;
        case ({status_byte[7:4], 4'h0})
            ST_NOTE_OFF: msg_type = NOTE_OFF;
            ST_NOTE_ON:  msg_type = NOTE_ON;
            ST_POLY_AT:  msg_type = POLY_AT;
            ST_CTRL:     msg_type = CTRL;
            ST_PROG:     begin msg_type = PROG;    two_data = 1'b0; end
            ST_CHAN_AT:  begin msg_type = CHAN_AT; two_data = 1'b0; end
            ST_PITCH:    msg_type = PITCH;
            default:     msg_type = NOTE_OFF;
        endcase
    end

    assign is_realtime    = (status_byte >= RT_MIN);
    assign is_sysex_start = (status_byte == SYSEX_START);
    assign is_syscommon   = (status_byte > SYSEX_START) && (status_byte < SYSEX_END);

endmodule

// File: rtl/midi_parser.sv
// MIDI voice-message parser with running status, SysEx skipping and a
// saturating count of orphaned data bytes.
//
// state     | meaning
// NO_STATUS | no running status; data bytes are dropped and counted
// WAIT_D1   | running status held, no data byte captured yet
// WAIT_D2   | first data byte captured, waiting for the second
// SYSEX     | inside system-exclusive; data bytes discarded uncounted
module midi_parser
    import midi_pkg::*;
#(
    parameter int         OMNI    = 1,
    parameter logic [3:0] CHANNEL = 4'd0
)(
    input  logic       clock,
    input  logic       reset,
    input  logic       ready,
    input  logic [7:0] MIDIbyte,
    output logic       msg_valid,
    output msg_type_t  msg_type,
    output logic [3:0] msg_channel,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic [7:0] drop_count
);

    parse_state_t state, state_nxt;
    msg_type_t    rs_type;
    logic [3:0]   rs_chan;
    logic         rs_two;
    logic [6:0]   data1_q;

    msg_type_t    dec_type;
    logic         dec_two, dec_rt, dec_sysex_start, dec_syscommon;

    logic         load_rs, clear_rs, cap_d1, complete, drop_inc;
    logic [6:0]   fin_d1, fin_d2;
    msg_type_t    fin_type;
    logic         chan_ok;

    midi_status_decode u_decode (
        .status_byte   (MIDIbyte),
        .msg_type      (dec_type),
        .two_data      (dec_two),
        .is_realtime   (dec_rt),
        .is_sysex_start(dec_sysex_start),
        .is_syscommon  (dec_syscommon)
    );

    always_comb begin
        state_nxt = state;
        load_rs   = 1'b0;
        clear_rs  = 1'b0;
        cap_d1    = 1'b0;
        complete  = 1'b0;
        drop_inc  = 1'b0;
        fin_d1    = data1_q;
        fin_d2    = MIDIbyte[6:0];
        if (ready && !dec_rt) begin
            if (MIDIbyte[7]) begin
                // A voice status also terminates SysEx and is taken as-is.
                if (MIDIbyte[7:4] != 4'hF) begin
                    load_rs   = 1'b1;
                    state_nxt = WAIT_D1;
                end else if (dec_sysex_start) begin
                    clear_rs  = 1'b1;
                    state_nxt = SYSEX;
                end else if (dec_syscommon || MIDIbyte == SYSEX_END) begin
                    clear_rs  = 1'b1;
                    state_nxt = NO_STATUS;
                end
            end else begin
                case (state)
                    NO_STATUS: drop_inc = 1'b1;
                    WAIT_D1: begin
                        if (rs_two) begin
                            cap_d1    = 1'b1;
                            state_nxt = WAIT_D2;
                        end else begin
                            complete = 1'b1;
                            fin_d1   = MIDIbyte[6:0];
                            fin_d2   = 7'd0;
                        end
                    end
                    WAIT_D2: begin
                        complete  = 1'b1;
                        state_nxt = WAIT_D1;
                    end
                    default: state_nxt = state;
                endcase
            end
        end
    end

    assign chan_ok  = (OMNI != 0) || (rs_chan == CHANNEL);
    assign fin_type = (rs_type == NOTE_ON && fin_d2 == 7'd0) ? NOTE_OFF : rs_type;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= NO_STATUS;
            rs_type <= NOTE_OFF;
            rs_chan <= 4'd0;
            rs_two  <= 1'b0;
            data1_q <= 7'd0;
        end else begin
            state <= state_nxt;
            if (load_rs) begin
                rs_type <= dec_type;
                rs_chan <= MIDIbyte[3:0];
                rs_two  <= dec_two;
                data1_q <= 7'd0;
            end else if (clear_rs) begin
                rs_type <= NOTE_OFF;
                rs_chan <= 4'd0;
                rs_two  <= 1'b0;
                data1_q <= 7'd0;
            end else if (cap_d1) begin
                data1_q <= MIDIbyte[6:0];
            end
        end
    end

    // Filtered-channel messages still advance the parser but never reach the outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            msg_valid   <= 1'b0;
            msg_type    <= NOTE_OFF;
            msg_channel <= 4'd0;
            msg_data1   <= 7'd0;
            msg_data2   <= 7'd0;
            drop_count  <= 8'd0;
        end else begin
            msg_valid <= complete && chan_ok;
            if (complete && chan_ok) begin
                msg_type    <= fin_type;
                msg_channel <= rs_chan;
                msg_data1   <= fin_d1;
                msg_data2   <= fin_d2;
            end
            if (drop_inc && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_midi_parser.sv
// Directed bench for midi_parser: omni instance plus a channel-3 filtered instance.
module tb_midi_parser;
    import midi_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] MIDIbyte = 8'h00;

    logic       msg_valid, msg_valid2;
    msg_type_t  msg_type, msg_type2;
    logic [3:0] msg_channel, msg_channel2;
    logic [6:0] msg_data1, msg_data2, msg_data1_2, msg_data2_2;
    logic [7:0] drop_count, drop_count2;

    int n_cmp = 0;
    int n_mis = 0;
    int n2    = 0;

    typedef struct { int t; int ch; int d1; int d2; } msg_s;
    msg_s got[$];

    always #10 clock = ~clock;

    midi_parser dut (
        .clock(clock), .reset(reset), .ready(ready), .MIDIbyte(MIDIbyte),
        .msg_valid(msg_valid), .msg_type(msg_type), .msg_channel(msg_channel),
        .msg_data1(msg_data1), .msg_data2(msg_data2), .drop_count(drop_count)
    );

    midi_parser #(.OMNI(0), .CHANNEL(4'd3)) dut_ch3 (
        .clock(clock), .reset(reset), .ready(ready), .MIDIbyte(MIDIbyte),
        .msg_valid(msg_valid2), .msg_type(msg_type2), .msg_channel(msg_channel2),
        .msg_data1(msg_data1_2), .msg_data2(msg_data2_2), .drop_count(drop_count2)
    );

    always @(negedge clock) begin
        if (msg_valid)
            got.push_back('{int'(msg_type), int'(msg_channel), int'(msg_data1), int'(msg_data2)});
        if (msg_valid2)
            n2++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        ready    = 1'b1;
        MIDIbyte = b;
        @(negedge clock);
        ready    = 1'b0;
        MIDIbyte = 8'h00;
        @(negedge clock);
    endtask

    task automatic settle();
        repeat (3) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        got.delete();
        n2 = 0;
    endtask

    task automatic check_msg(input string tag, input int idx, input int t, input int ch,
                             input int d1, input int d2);
        if (got.size() > idx) begin
            check({tag, ".type"}, got[idx].t, t);
            check({tag, ".chan"}, got[idx].ch, ch);
            check({tag, ".d1"}, got[idx].d1, d1);
            check({tag, ".d2"}, got[idx].d2, d2);
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("rst.valid", int'(msg_valid), 0);
        check("rst.type", int'(msg_type), int'(NOTE_OFF));
        check("rst.chan", int'(msg_channel), 0);
        check("rst.d1", int'(msg_data1), 0);
        check("rst.d2", int'(msg_data2), 0);
        check("rst.drop", int'(drop_count), 0);
        reset = 1'b1;
        @(negedge clock);

        // Basic note-on
        send_byte(8'h92); send_byte(8'h3C); send_byte(8'h64); settle();
        check("non.count", got.size(), 1);
        check_msg("non", 0, 1, 2, 8'h3C, 8'h64);

        // Running status and velocity-0 note-on
        do_reset();
        send_byte(8'h90); send_byte(8'h40); send_byte(8'h50);
        send_byte(8'h41); send_byte(8'h00); settle();
        check("rs.count", got.size(), 2);
        check_msg("rs0", 0, 1, 0, 8'h40, 8'h50);
        check_msg("rs1", 1, 0, 0, 8'h41, 8'h00);

        // One-data-byte program change with running status
        do_reset();
        send_byte(8'hC5); send_byte(8'h07); send_byte(8'h08); settle();
        check("prog.count", got.size(), 2);
        check_msg("prog0", 0, 4, 5, 8'h07, 0);
        check_msg("prog1", 1, 4, 5, 8'h08, 0);

        // Real-time byte inside a message
        do_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h7F); settle();
        check("rt.count", got.size(), 1);
        check_msg("rt", 0, 1, 0, 8'h3C, 8'h7F);

        // SysEx then stray byte
        do_reset();
        send_byte(8'hF0); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'hF7); send_byte(8'h3C); settle();
        check("sx.count", got.size(), 0);
        check("sx.drop", int'(drop_count), 1);

        // SysEx terminated by a voice status
        do_reset();
        send_byte(8'hF0); send_byte(8'h01); send_byte(8'h91);
        send_byte(8'h3C); send_byte(8'h40); settle();
        check("sxv.count", got.size(), 1);
        check_msg("sxv", 0, 1, 1, 8'h3C, 8'h40);
        check("sxv.drop", int'(drop_count), 0);

        // Status in WAIT_D2 abandons partial message; outputs then hold
        do_reset();
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hB1);
        send_byte(8'h07); send_byte(8'h10); settle();
        check("ab.count", got.size(), 1);
        check_msg("ab", 0, 3, 1, 8'h07, 8'h10);
        check("ab.drop", int'(drop_count), 0);
        repeat (5) @(negedge clock);
        check("hold.valid", int'(msg_valid), 0);
        check("hold.d1", int'(msg_data1), 8'h07);
        check("hold.d2", int'(msg_data2), 8'h10);

        // System-common clears running status; its data byte is counted
        do_reset();
        send_byte(8'h90); send_byte(8'hF2); send_byte(8'h05); send_byte(8'h06); settle();
        check("sc.count", got.size(), 0);
        check("sc.drop", int'(drop_count), 2);

        // Channel filtering on the OMNI=0, CHANNEL=3 instance
        do_reset();
        send_byte(8'h93); send_byte(8'h3C); send_byte(8'h64); settle();
        check("f3.count", n2, 1);
        check("f3.chan", int'(msg_channel2), 3);
        check("f3.d2", int'(msg_data2_2), 8'h64);
        send_byte(8'h92); send_byte(8'h3D); send_byte(8'h65); settle();
        check("f2.count", n2, 1);
        check("f2.d1", int'(msg_data1_2), 8'h3C);
        check("f2.drop", int'(drop_count2), 0);
        check("f2.omni", got.size(), 2);

        // Reset mid-message
        do_reset();
        send_byte(8'h90); send_byte(8'h3C);
        do_reset();
        send_byte(8'h64); settle();
        check("mr.count", got.size(), 0);
        check("mr.drop", int'(drop_count), 1);

        // Saturation of the drop counter
        do_reset();
        for (int i = 0; i < 254; i++) send_byte(8'h11);
        settle();
        check("sat.254", int'(drop_count), 8'hFE);
        for (int i = 0; i < 46; i++) send_byte(8'h11);
        settle();
        check("sat.300", int'(drop_count), 8'hFF);
        check("sat.count", got.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/midi_parser.md
MIDI_PARSER -- requirements
Module: midi_parser

Interface
REQ-001 Parameter: OMNI, default 1, when 1 accept voice messages on all channels.
REQ-002 Parameter: CHANNEL, default 4'd0, only channel accepted when OMNI=0.
REQ-003 Port: clock  input  1  system clock, 50 MHz domain.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: ready  input  1  one-cycle strobe from the deserializer; MIDIbyte valid this cycle.
REQ-006 Port: MIDIbyte  input  8  received MIDI byte.
REQ-007 Port: msg_valid  output  1  one-cycle strobe: a complete voice message is on the msg_* outputs.
REQ-008 Port: msg_type  output  3  msg_type_t: NOTE_OFF, NOTE_ON, POLY_AT, CTRL, PROG, CHAN_AT, PITCH.
REQ-009 Port: msg_channel  output  4  channel nibble of the governing status.
REQ-010 Port: msg_data1  output  7  first data byte, such as a note or controller number.
REQ-011 Port: msg_data2  output  7  second data byte, or 0 for one-data-byte messages.
REQ-012 Port: drop_count  output  8  saturating count of discarded data bytes.

Function
REQ-013 Bytes are sampled only on cycles with ready=1; all other cycles do not change state.
REQ-014 Status bytes 0x80-0xEF set the running status, clear partial data and go to WAIT_D1.
  - Running status is kept as type plus channel.
REQ-015 Expected data count: 2 for 0x8n, 0x9n, 0xAn, 0xBn and 0xEn; 1 for 0xCn and 0xDn.
REQ-016 States:
  - NO_STATUS: no running status.
  - WAIT_D1: running status held, no data byte captured yet.
  - WAIT_D2: first data byte captured.
  - SYSEX: inside a system-exclusive message.
REQ-017 A data byte (bit7=0) in WAIT_D1 is handled by message length.
  - One-data-byte status: complete the message and stay in WAIT_D1.
  - Two-data-byte status: capture data1 and go to WAIT_D2.
REQ-018 A data byte in WAIT_D2 completes the message and returns to WAIT_D1 (running status).
REQ-019 Completing a message asserts msg_valid for exactly one cycle, the cycle after the ready that carried the final byte.
  - msg_* outputs update on that same edge.
REQ-020 msg_* outputs are registered and hold their value until the next completed message.
REQ-021 NOTE_ON with velocity 0 is reported as NOTE_OFF with msg_data2=0.
REQ-022 When OMNI=0 and the channel differs from CHANNEL, the message is parsed but msg_valid is not asserted.
  - drop_count is not incremented for these messages.
REQ-023 Real-time bytes 0xF8-0xFF are ignored in every state.
  - Running status, partial data and state are left untouched.
REQ-024 0xF0 goes to SYSEX and clears running status.
  - Data bytes in SYSEX are discarded silently and are not counted.
REQ-025 0xF7, or any status byte 0x80-0xF6, ends SYSEX; that byte is then processed normally.
  - 0xF7 leads to NO_STATUS.
REQ-026 System-common bytes 0xF1-0xF6 clear running status and go to NO_STATUS.
  - Their data bytes are discarded and counted.
REQ-027 A data byte in NO_STATUS is discarded and increments drop_count.
REQ-028 A status byte arriving in WAIT_D2 abandons the partial message without counting it.
REQ-029 drop_count saturates at 8'hFF and never wraps.

Reset
REQ-030 While reset=0, the block is held in its reset state, asynchronously.
  - State is NO_STATUS and running status is cleared.
  - msg_valid=0, msg_type=NOTE_OFF, msg_channel=0, msg_data1=0, msg_data2=0, drop_count=0.
REQ-031 Asserting reset mid-message discards the partial message; no msg_valid follows deassertion.
REQ-032 Deassertion is used synchronised to clock by the top level; the block adds no synchroniser.

Structure
REQ-033 Package midi_pkg holds shared definitions:
  - msg_type_t enum and the parser state enum.
  - Status-nibble constants (8'h80-8'hE0).
  - SYSEX_START=8'hF0, SYSEX_END=8'hF7, RT_MIN=8'hF8.
REQ-034 One combinational sub-module, midi_status_decode, maps a status byte to type, data count, is_realtime, is_sysex_start and is_syscommon.
REQ-035 Everything else lives in midi_parser: FSM, data registers, output registers and counter.

Verification
REQ-036 Bytes 0x92, 0x3C, 0x64 -> one msg_valid pulse with NOTE_ON, channel 2, data1 0x3C, data2 0x64.
REQ-037 Bytes 0x90, 0x40, 0x50, 0x41, 0x00 -> two pulses.
  - First: NOTE_ON 0x40/0x50.
  - Second: NOTE_OFF 0x41/0x00 (running status plus velocity-0 rule).
REQ-038 Bytes 0xC5, 0x07, 0x08 -> two pulses, PROG channel 5, data1 0x07 then 0x08, data2 0 each.
REQ-039 Bytes 0x90, 0x3C, 0xF8, 0x7F -> one pulse NOTE_ON 0x3C/0x7F; the real-time byte has no effect.
REQ-040 Bytes 0xF0, 0x01, 0x02, 0xF7, 0x3C -> no pulse, drop_count=1.
REQ-041 Sequences:
  - Reset pulsed low after bytes 0x90, 0x3C, then byte 0x64 -> no pulse, drop_count=1.
  - 300 stray data bytes after reset -> drop_count=0xFF.
